// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
// Optional checksum word is enabled by defining REGFILE_DUMP_CHECKSUM_EN.
package regfile_dump_pkg;

    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_ADDR_W   = 5;
    localparam int REGFILE_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One buffered stream word: register value, its index, end-of-dump marker.
    typedef struct packed {
        logic [REGFILE_DATA_W-1:0] data;
        logic [REGFILE_ADDR_W-1:0] addr;
        logic                      last;
    } skid_entry_t;

endpackage

// File: rtl/regfile_dump_skid.sv
// Two-entry FIFO holding returned register words until the stream accepts them.
// The head entry is presented combinationally and stays put until popped.
module regfile_dump_skid
    import regfile_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  skid_entry_t push_entry,
    input  logic        pop,
    output logic [1:0]  count,
    output skid_entry_t head
);

    skid_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage write, pointer advance and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset as well as the pointers because the
            // head entry drives dump_data/dump_addr directly and must read 0 after reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // The issue throttle upstream guarantees room; either of these firing is a design error.
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (count == 2'd2)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && (count == 2'd0)));

endmodule

// File: rtl/regfile_dump.sv
// Debug reader that walks the register file on one synchronous read port and
// streams every register out on a valid/ready interface, ascending by address.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word to each dump.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter bit SKIP_X0  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regReadData,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last
);

    // Walk counter is one bit wider than the address so reaching NUM_REGS never wraps.
    localparam logic [ADDR_W:0]   FIRST_CNT = SKIP_X0 ? (ADDR_W+1)'(1) : '0;
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   rd_cnt;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_pop;
    logic [2:0]        occupancy;
    logic              push;
    skid_entry_t       push_entry;
    logic [1:0]        fifo_count;
    skid_entry_t       head;

    assign regAddr    = rd_cnt[ADDR_W-1:0];
    assign dump_valid = (fifo_count != 2'd0);
    assign dump_data  = DATA_W'(head.data);
    assign dump_addr  = ADDR_W'(head.addr);
    assign dump_last  = head.last;
    assign pop        = dump_valid & dump_ready;
    assign last_pop   = pop & head.last;

    // Words that will sit in the buffer after this edge, counting the read still in flight.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: walk issues reads, drain waits for the final word to leave.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start)                          state_nxt = ISSUE;
            ISSUE:   if (issue && (rd_cnt == LAST_CNT))  state_nxt = DRAIN;
            DRAIN:   if (last_pop)                       state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag, start acceptance and the read-issue throttle.
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        issue  = (state == ISSUE) && (occupancy < 3'd2);
    end

    // Walk counter, in-flight read tag and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            done          <= 1'b0;
        end else begin
            done     <= last_pop;
            inflight <= issue;
            if (issue) begin
                inflight_addr <= regAddr;
            end
            if (accept) begin
                rd_cnt <= FIRST_CNT;
            end else if (issue) begin
                rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] xor_acc;
    logic              ck_pending;
    logic              ck_push;

    // Every buffered word is eventually emitted, so folding words in as they enter
    // the buffer yields the XOR of the emitted words without waiting for the last pop.
    assign ck_push = ck_pending && ((fifo_count != 2'd2) || pop);

    // Running XOR and the pending-checksum flag, cleared at each new dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc    <= '0;
            ck_pending <= 1'b0;
        end else if (accept) begin
            xor_acc    <= '0;
            ck_pending <= 1'b0;
        end else begin
            if (inflight) begin
                xor_acc <= xor_acc ^ regReadData;
            end
            if (inflight && (inflight_addr == LAST_ADDR)) begin
                ck_pending <= 1'b1;
            end else if (ck_push) begin
                ck_pending <= 1'b0;
            end
        end
    end

    // Buffer input: returning register data, or the checksum word once the walk is captured.
    always_comb begin
        push       = inflight | ck_push;
        push_entry = '0;
        if (inflight) begin
            push_entry.data = REGFILE_DATA_W'(regReadData);
            push_entry.addr = REGFILE_ADDR_W'(inflight_addr);
            push_entry.last = 1'b0;
        end else if (ck_push) begin
            push_entry.data = REGFILE_DATA_W'(xor_acc);
            push_entry.addr = '0;
            push_entry.last = 1'b1;
        end
    end
`else
    // Buffer input: returning register data, tagged with its address and end marker.
    always_comb begin
        push            = inflight;
        push_entry      = '0;
        push_entry.data = REGFILE_DATA_W'(regReadData);
        push_entry.addr = REGFILE_ADDR_W'(inflight_addr);
        push_entry.last = (inflight_addr == LAST_ADDR);
    end
`endif

    regfile_dump_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head       (head)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: ready-pattern scenarios from a table,
// plus hand-written sequences for ignored/back-to-back start and mid-dump reset.
module tb_regfile_dump;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dump_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          dump_valid;
    logic          dump_last;
    logic [AW-1:0] regAddr;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] regReadData;
    logic [DW-1:0] dump_data;
    logic [DW-1:0] regs [NR];

    int errors = 0;
    int checks = 0;
    int reg_addr_at11;

    typedef struct {
        int    mode;       // 0: ready high, 1: toggling, 2: low for 10 cycles after first valid
        int    exp_first;  // cycle of first dump_valid after the start edge
        int    exp_done;   // cycle in which done pulses
        int    exp_words;  // words handed over
        string name;
    } vec_t;

    vec_t vecs [3];

    regfile_dump dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .regAddr     (regAddr),
        .regReadData (regReadData),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .dump_last   (dump_last)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous read, data one cycle after the address.
    always @(posedge clk) regReadData <= regs[regAddr];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int n);
        case (mode)
            1:       return (n % 2 == 0);
            2:       return !(n >= 2 && n < 12);
            default: return 1'b1;
        endcase
    endfunction

    // Start a dump now (start sampled on the next edge, cycle 0) and monitor it.
    // spurious: cycle in which start is pulsed again; abort_addr: return once that word is taken.
    task automatic run_dump(input int mode, input int exp_first, input int exp_done,
                            input int exp_words, input int spurious, input int abort_addr,
                            input string tag);
        int            cyc, first_valid, done_cyc, words, stall_bad, max_out, exp_addr;
        logic [DW-1:0] exp_xor;
        logic [63:0]   cur_word, prev_word, exp_word;
        logic          prev_hold;
        bit            fin, aborted;
        cyc = 0; first_valid = -1; done_cyc = -1; words = 0; stall_bad = 0; max_out = 0;
        exp_addr = 1; exp_xor = '0; prev_word = '0; prev_hold = 1'b0; fin = 0; aborted = 0;
        start = 1'b1;
        dump_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        dump_ready = ready_for(mode, 0);
        while (!fin && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
                check({tag, "_done_low_at_start"}, 64'(done), 64'(0));
            end
            if (cyc == 11) reg_addr_at11 = int'(regAddr);
            if (busy && (int'(regAddr) - exp_addr > max_out)) max_out = int'(regAddr) - exp_addr;
            cur_word = {25'd0, dump_valid, dump_last, dump_addr, dump_data};
            if (prev_hold && (cur_word !== prev_word)) stall_bad++;
            if (dump_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_addr < NR)
                    exp_word = {25'd0, 1'b1, (exp_addr == NR - 1) && (EXTRA == 0), AW'(exp_addr), regs[exp_addr]};
                else
                    exp_word = {25'd0, 1'b1, 1'b1, AW'(0), exp_xor};
                if (dump_ready) begin
                    check($sformatf("%s_word%0d", tag, words), cur_word, exp_word);
                    if (exp_addr < NR) exp_xor = exp_xor ^ regs[exp_addr];
                    words++;
                    if (exp_addr == abort_addr) begin
                        aborted = 1;
                        fin = 1;
                    end
                    exp_addr++;
                end
            end
            prev_hold = dump_valid && !dump_ready;
            prev_word = cur_word;
            if (done && !fin) begin
                done_cyc = cyc;
                fin = 1;
                check({tag, "_busy_low_at_done"}, 64'(busy), 64'(0));
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
                dump_ready = ready_for(mode, cyc);
                start = (cyc == spurious);
            end
        end
        start = 1'b0;
        if (abort_addr < 0) begin
            check({tag, "_first_valid_cycle"}, 64'(first_valid), 64'(exp_first));
            check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
            check({tag, "_word_count"}, 64'(words), 64'(exp_words));
            check({tag, "_stall_hold_errors"}, 64'(stall_bad), 64'(0));
            check({tag, "_outstanding_le3"}, 64'(max_out <= 3), 64'(1));
        end else begin
            check({tag, "_abort_word_reached"}, 64'(aborted), 64'(1));
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            regs[i] = 32'hFFFF_FFFF;
`else
            regs[i] = 32'h1000_0000 + i;
`endif
        end

        vecs[0] = '{0, 2, 33 + EXTRA,     NR - 1 + EXTRA, "ready_high"};
        vecs[1] = '{1, 2, 63 + 2 * EXTRA, NR - 1 + EXTRA, "ready_toggle"};
        vecs[2] = '{2, 2, 43 + EXTRA,     NR - 1 + EXTRA, "ready_stall10"};

        // Reset state.
        #12;
        check("reset_busy",      64'(busy),       64'(0));
        check("reset_done",      64'(done),       64'(0));
        check("reset_valid",     64'(dump_valid), 64'(0));
        check("reset_last",      64'(dump_last),  64'(0));
        check("reset_dump_data", 64'(dump_data),  64'(0));
        check("reset_dump_addr", 64'(dump_addr),  64'(0));
        check("reset_reg_addr",  64'(regAddr),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven ready patterns.
        for (int i = 0; i < 3; i++) begin
            run_dump(vecs[i].mode, vecs[i].exp_first, vecs[i].exp_done, vecs[i].exp_words,
                     -1, -1, vecs[i].name);
            if (vecs[i].mode == 2) check("stall_reg_addr_held", 64'(reg_addr_at11), 64'(3));
            repeat (3) @(negedge clk);
        end

        // Start pulsed mid-dump is ignored; start in the done cycle begins a new dump.
        run_dump(0, 2, 33 + EXTRA, NR - 1 + EXTRA, 5, -1, "spurious_start");
        run_dump(0, 2, 33 + EXTRA, NR - 1 + EXTRA, -1, -1, "start_in_done");
        repeat (3) @(negedge clk);

        // Reset right after the word with address 10 is accepted.
        run_dump(0, 2, 0, 0, -1, 10, "abort");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_valid",    64'(dump_valid), 64'(0));
        check("midreset_busy",     64'(busy),       64'(0));
        check("midreset_last",     64'(dump_last),  64'(0));
        check("midreset_reg_addr", 64'(regAddr),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dump(0, 2, 33 + EXTRA, NR - 1 + EXTRA, -1, -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the RISC-V register file.
- On a start pulse it walks the register addresses in order and issues synchronous reads on one register-file read port.
- Read data returns one cycle after the address and is streamed out on a valid/ready interface.
- Sits between the halted core's register file and the debug/UART trace path; the port mux selecting it over the decode stage lives outside this block.

Parameters:
- NUM_REGS, 32, number of registers walked.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- SKIP_X0, 1, when 1 the walk starts at address 1 (x0 is never dumped); when 0 it starts at 0.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a dump; sampled only while busy=0.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final word handshake.
- regAddr  output  ADDR_W  read address to the register file.
- regReadData  input  DATA_W  register file read data, valid one cycle after regAddr.
- dump_valid  output  1  stream word valid.
- dump_ready  input  1  downstream accept.
- dump_data  output  DATA_W  register value.
- dump_addr  output  ADDR_W  register index of dump_data.
- dump_last  output  1  marks the final word of the dump.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, dump_valid, dump_last = 0; dump_data, dump_addr, regAddr = 0; skid buffer emptied; in-flight read discarded.
- States: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start=1.
  - ISSUE -> DRAIN after the read of address NUM_REGS-1 is issued.
  - DRAIN -> IDLE on the handshake of the last word.
  - done pulses in the first IDLE cycle.
  - busy=0 in that cycle, so a start in the done cycle is accepted.
- Read issue:
  - In ISSUE, regAddr presents the next address and a read counts as issued that cycle if (buffered + inflight - pop) < 2.
  - pop = dump_valid & dump_ready this cycle.
  - Otherwise regAddr holds and no read is issued.
- Capture:
  - Data returning the cycle after issue is pushed into a 2-entry FIFO tagged with its address.
  - The FIFO can never overflow; an overflow condition is a design error.
- Latency and throughput:
  - With dump_ready held at 1, the first dump_valid appears 2 cycles after the start edge.
  - One word per cycle thereafter, no bubbles.
- Stream rules:
  - dump_data, dump_addr and dump_last are stable while dump_valid & !dump_ready.
  - dump_valid never drops without a handshake, except on reset.
- Ordering: words are emitted in strictly ascending address, no drops or duplicates under any ready pattern.
- dump_last is 1 only on the word with address NUM_REGS-1, or on the checksum word when enabled.
- start while busy=1 is ignored.
- Counters are ADDR_W+1 bits wide so the end-of-walk compare at NUM_REGS does not wrap.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- When defined:
  - A running XOR of every emitted dump_data is kept.
  - After the register words, one extra word is emitted with dump_data = XOR, dump_addr = 0 and dump_last = 1.
  - The register word at NUM_REGS-1 then has dump_last = 0.
  - done follows the checksum handshake.
- When undefined: no XOR register, no extra word.

Decomposition:
- Package regfile_dump_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - default constants REGFILE_NUM_REGS=32, REGFILE_ADDR_W=5, REGFILE_DATA_W=32;
  - the skid-entry struct {data, addr, last}.
- One sub-module, regfile_dump_skid: a 2-entry FIFO with push/pop, count and head outputs.

Test Plan:
- Regs preloaded with 0x1000_0000+i, SKIP_X0=1, ready held at 1, start at cycle 0.
  - Expect 31 words, addr 1..31, data 0x1000_0001..0x1000_001F, on consecutive cycles 2..32.
  - dump_last with addr 31; done pulse at cycle 33.
- Same preload, dump_ready toggling 1,0,1,0.
  - Identical word sequence.
  - Data/addr stable on every stalled cycle.
  - Never more than 2 buffered words, plus at most 1 in flight.
- dump_ready low for 10 cycles after the first valid.
  - regAddr stops advancing at addr 3, since addrs 1 and 2 are buffered.
  - On release, addr 1 comes out first, then 2, 3, ... with no gaps.
- start pulsed at cycle 5 mid-dump is ignored.
  - start in the done cycle begins a new dump: first valid 2 cycles later, addr 1.
- rst_n asserted after the word with addr 10 is accepted.
  - dump_valid and busy fall immediately.
  - After release and a new start, the dump restarts at addr 1 with full content.
- With REGFILE_DUMP_CHECKSUM_EN and all regs = 0xFFFF_FFFF: 31 words, then an extra word with data 0xFFFF_FFFF, addr 0, last=1.
  - Word 31 has last=0.
